// File: rtl/seq_mult_param.sv
// ============================================================================
// Module   : seq_mult_param
// Purpose  : Radix-2 shift-and-add sequential multiplier, one multiplier bit
//            per clock, run-time signed/unsigned, back-to-back capable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_en,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               out_en,
    output logic [2*WIDTH-1:0] prdct
);

    localparam int               c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_count;
    logic [2*WIDTH:0]     r_acc;
    logic [WIDTH-1:0]     r_a;
    logic                 r_mode;
    logic [2*WIDTH-1:0]   r_prdct;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_ext;
    logic [WIDTH:0]       w_hi_upd;
    logic                 w_fill;
    logic [2*WIDTH:0]     w_acc_shift;

    assign w_accept = in_en && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_count == c_last);

    // High part carries one guard bit so the running sum never overflows.
    always_comb begin
        w_ext    = {r_mode & r_a[WIDTH-1], r_a};
        w_hi_upd = r_acc[2*WIDTH:WIDTH];
        if (r_acc[0]) begin
            // The multiplier MSB carries negative weight in two's complement.
            if (r_mode && w_last) begin
                w_hi_upd = r_acc[2*WIDTH:WIDTH] - w_ext;
            end else begin
                w_hi_upd = r_acc[2*WIDTH:WIDTH] + w_ext;
            end
        end
        w_fill      = r_mode & w_hi_upd[WIDTH];
        w_acc_shift = {w_fill, w_hi_upd, r_acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = in_en ? S_CALC : S_IDLE;
            S_CALC:  w_state_nxt = w_last ? S_DONE : S_CALC;
            S_DONE:  w_state_nxt = in_en ? S_CALC : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_mode  <= 1'b0;
            r_prdct <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_mode  <= signed_mode;
            r_acc   <= {{(WIDTH+1){1'b0}}, b};
            r_count <= '0;
        end else if (r_state == S_CALC) begin
            r_acc   <= w_acc_shift;
            r_count <= r_count + c_cnt_w'(1);
            if (w_last) begin
                r_prdct <= w_acc_shift[2*WIDTH-1:0];
            end
        end
    end

    assign busy   = (r_state == S_CALC);
    assign out_en = (r_state == S_DONE);
    assign prdct  = r_prdct;

endmodule

`default_nettype wire

// File: tb/tb_seq_mult_param.sv
// ============================================================================
// Module   : tb_seq_mult_param
// Purpose  : Directed and randomized checks of seq_mult_param at W=8/16/4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en8 = 0, m8 = 0, busy8, oe8;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] p8;
    logic        en16 = 0, m16 = 0, busy16, oe16;
    logic [15:0] a16 = 0, b16 = 0;
    logic [31:0] p16;
    logic        en4 = 0, m4 = 0, busy4, oe4;
    logic [3:0]  a4 = 0, b4 = 0;
    logic [7:0]  p4;

    seq_mult_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_en(en8), .signed_mode(m8),
        .a(a8), .b(b8), .busy(busy8), .out_en(oe8), .prdct(p8));
    seq_mult_param #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_en(en16), .signed_mode(m16),
        .a(a16), .b(b16), .busy(busy16), .out_en(oe16), .prdct(p16));
    seq_mult_param #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_en(en4), .signed_mode(m4),
        .a(a4), .b(b4), .busy(busy4), .out_en(oe4), .prdct(p4));

    int cur = 8;
    int n_cmp = 0;
    int n_bad = 0;

    logic        s_busy, s_oe;
    logic [63:0] s_prdct;
    assign s_busy  = (cur == 16) ? busy16 : (cur == 4) ? busy4 : busy8;
    assign s_oe    = (cur == 16) ? oe16   : (cur == 4) ? oe4   : oe8;
    assign s_prdct = (cur == 16) ? 64'(p16) : (cur == 4) ? 64'(p4) : 64'(p8);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [31:0] av, input logic [31:0] bv, input logic m);
        case (cur)
            16: begin en16 = en; a16 = av[15:0]; b16 = bv[15:0]; m16 = m; end
            4:  begin en4  = en; a4  = av[3:0];  b4  = bv[3:0];  m4  = m; end
            default: begin en8 = en; a8 = av[7:0]; b8 = bv[7:0]; m8 = m; end
        endcase
    endtask

    // Reference: interpret operands as plain integers and multiply.
    function automatic logic [63:0] ref_mult(input int w, input logic [31:0] av,
                                             input logic [31:0] bv, input logic m);
        longint x, y, p;
        longint mask;
        mask = (longint'(1) << w) - 1;
        x = longint'(av) & mask;
        y = longint'(bv) & mask;
        if (m && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
        if (m && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
        p = x * y;
        return 64'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // One operation on the selected instance; random noise on the inputs
    // (including in_en) while it is busy must not disturb the result.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic m, input logic [63:0] expv);
        int lat;
        int busy_n;
        drive(1'b1, av, bv, m);
        tick();
        lat = 1;
        busy_n = 0;
        while (!s_oe && lat < 64) begin
            if (s_busy) busy_n++;
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            tick();
            lat++;
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        check({tag, "/prdct"}, s_prdct, expv);
        check({tag, "/latency"}, 64'(lat), 64'(cur + 1));
        check({tag, "/busy_cycles"}, 64'(busy_n), 64'(cur));
        check({tag, "/busy_at_done"}, 64'(s_busy), 64'd0);
    endtask

    initial begin
        logic [63:0] exp_q[$];
        logic [31:0] ra, rb;
        logic        rm;
        int          n_oe;

        // Reset and idle
        cur = 8;
        #3;
        check("rst/prdct", s_prdct, 64'h0);
        check("rst/out_en", 64'(s_oe), 64'd0);
        check("rst/busy", 64'(s_busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle/outputs", {s_prdct[61:0], s_oe, s_busy}, 64'h0);
        end

        // Unsigned extremes and signed corners, W=8
        run_op("u255x255", 32'd255, 32'd255, 1'b0, 64'hFE01);
        run_op("u0x200",   32'd0,   32'd200, 1'b0, 64'h0000);
        run_op("s-3x5",    32'hFD,  32'd5,   1'b1, 64'hFFF1);
        run_op("s-128x-128", 32'h80, 32'h80, 1'b1, 64'h4000);
        run_op("s-128x127",  32'h80, 32'h7F, 1'b1, 64'hC080);
        run_op("u253x5",   32'd253, 32'd5,   1'b0, 64'h04F1);
        run_op("u128x128", 32'd128, 32'd128, 1'b0, 64'h4000);
        run_op("u128x127", 32'd128, 32'd127, 1'b0, 64'h3F80);

        // Back-to-back with in_en held high and fresh operands every cycle
        ra = $urandom; rb = $urandom; rm = 1'($urandom_range(0, 1));
        exp_q.push_back(ref_mult(8, ra, rb, rm));
        drive(1'b1, ra, rb, rm);
        tick();
        n_oe = 0;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            check("b2b/out_en_timing", 64'(s_oe), 64'((cyc % 9) == 0));
            if (s_oe) begin
                n_oe++;
                if (exp_q.size() > 0) check("b2b/prdct", s_prdct, exp_q.pop_front());
            end
            ra = $urandom; rb = $urandom; rm = 1'($urandom_range(0, 1));
            if ((cyc % 9) == 0 && cyc < 36) exp_q.push_back(ref_mult(8, ra, rb, rm));
            drive(cyc < 36, ra, rb, rm);
            tick();
        end
        check("b2b/pulses", 64'(n_oe), 64'd4);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        repeat (2) tick();

        // Reset in the middle of a calculation
        run_op("pre_rst", 32'd100, 32'd3, 1'b0, 64'd300);
        drive(1'b1, 32'd7, 32'd9, 1'b0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst/prdct", s_prdct, 64'h0);
        check("midrst/out_en", 64'(s_oe), 64'd0);
        check("midrst/busy", 64'(s_busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_oe = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (s_oe) n_oe++;
        end
        check("midrst/no_out_en", 64'(n_oe), 64'd0);
        run_op("after_rst", 32'd7, 32'd9, 1'b0, 64'h003F);

        // Width sweep
        cur = 16;
        run_op("w16/s-32768x32767", 32'h8000, 32'h7FFF, 1'b1, 64'hC0008000);
        run_op("w16/u65535sq", 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE0001);
        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom; rm = 1'($urandom_range(0, 1));
            run_op("w16/rand", ra, rb, rm, ref_mult(16, ra, rb, rm));
        end

        cur = 4;
        for (int md = 0; md < 2; md++) begin
            for (int i = 0; i < 1000; i++) begin
                ra = $urandom; rb = $urandom;
                run_op(md ? "w4/rand_signed" : "w4/rand_unsigned", ra, rb, 1'(md),
                       ref_mult(4, ra, rb, 1'(md)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_mult_param.md
# seq_mult_param

Parametrised radial-2 sequential multiplier: one multiplier bit per clock, shift-and-add with a final subtract for two's-complement operands. It is the next generation of the team's 8-bit FSM multiplier and adds:
- a width parameter;
- run-time signed/unsigned selection;
- a busy flag;
- a carry-safe accumulator;
- back-to-back operation.

It sits between a producer that issues operand pairs with a one-cycle strobe and a consumer that takes the product on a one-cycle valid pulse.

## Interface
- WIDTH, 8, operand width W in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_en  in  1  start strobe; a, b and signed_mode are sampled on the same edge.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned.
- a  in  W  multiplicand.
- b  in  W  multiplier.
- busy  out  1  high while in CALC.
- out_en  out  1  one-cycle product-valid pulse.
- prdct  out  2W  product register; holds its value until the next result is loaded.

## Operation
- States: IDLE, CALC, DONE. One-hot or binary encoding is free; unused encodings return to IDLE.
- IDLE:
  - in_en=1 accepts the operation.
  - Latch a into a_reg, signed_mode into mode_reg, b into the low half of acc, and clear the high part of acc (W+1 bits).
  - Clear count and go to CALC.
- CALC, once per cycle, for count = 0..W-1:
  - If acc[0]=1, the high part gets hi ± ext(a_reg).
  - Subtract only when mode_reg=1 and count=W-1. Otherwise add.
  - ext() is a sign-extension to W+1 bits when mode_reg=1 and a zero-extension otherwise.
  - Then shift all of acc right by 1. The fill bit is the MSB of the updated high part in signed mode and 0 in unsigned mode.
  - count increments. When count=W-1, load prdct with acc[2W-1:0] after the shift and go to DONE.
- DONE:
  - out_en=1.
  - in_en=1 accepts a new operation exactly as in IDLE and goes to CALC. Otherwise go to IDLE.
- in_en while in CALC is ignored. Operands are not captured and the running operation is unaffected.
- Arithmetic:
  - The high part is W+1 bits, so no carry or sign is lost.
  - The result is exact: unsigned 0..(2^W-1)^2, signed -(2^(W-1))·(2^(W-1)-1) .. 2^(2W-2).
  - a and b may change freely after the accept edge.
- Reset (rst_n=0, any time including mid-CALC), immediately:
  - state=IDLE, count=0, acc=0, a_reg=0, mode_reg=0;
  - prdct=0, out_en=0, busy=0.
  - The interrupted operation is lost and produces no out_en.

## Timing
- Accept edge E0: in_en=1 while in IDLE or DONE. busy rises after E0.
- CALC lasts exactly W cycles, edges E1..EW. busy is high during those cycles only.
- prdct is updated at EW. out_en is high for the single cycle after EW.
- Latency: out_en is asserted W+1 cycles after the accept edge.
- Maximum throughput is one product every W+1 cycles, with in_en held high or re-pulsed during DONE.
- prdct is stable from EW until the next load or reset. It never shows intermediate values.
- out_en and busy are never high together.
- No combinational path from inputs to outputs.

## Test plan
- Reset and idle (W=8):
  - Assert rst_n=0 -> prdct=0x0000, out_en=0, busy=0.
  - Release reset with in_en=0 for 20 cycles -> outputs unchanged.
- Unsigned extremes (W=8):
  - a=255, b=255, signed_mode=0 -> prdct=0xFE01 (65025) and out_en pulse exactly 9 cycles after accept; busy high for 8 cycles.
  - a=0, b=200 -> 0x0000.
- Signed corners (W=8):
  - -3×5 -> 0xFFF1.
  - -128×-128 -> 0x4000.
  - -128×127 -> 0xC080.
  - Same bit patterns unsigned: 253×5 -> 0x04F1; 128×128 -> 0x4000; 128×127 -> 0x3F80.
- Back-to-back and ignore (W=8):
  - Hold in_en=1 with new operands every cycle -> one out_en every 9 cycles.
  - Each result matches the operands present on its accept edge.
  - Operands presented during CALC never appear in any result.
- Reset mid-operation (W=8):
  - Start 7×9, then pull rst_n low at CALC cycle 4 -> outputs go to 0 immediately and no out_en follows.
  - A subsequent 7×9 -> 0x003F.
- Width sweep:
  - WIDTH=16: signed -32768×32767 -> 0xC0008000; unsigned 65535×65535 -> 0xFFFE0001; latency 17 cycles.
  - WIDTH=4: 1000 random products per mode checked against a reference model.
